// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter. Sends a captured WIDTH-bit pattern MSB-first on j, (frames+1) times, with GAP idle cycles between frames.
// Moore outputs decoded from registered state only. start is honoured only in IDLE and ignored in every other state.
module seq_pattern_tx #(
    parameter int WIDTH = 4,
    parameter int GAP   = 2,
    localparam int IW   = (WIDTH > 2) ? $clog2(WIDTH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] data,
    input  logic [2:0]       frames,
    output logic             j,
    output logic             busy,
    output logic             done,
    output logic [IW-1:0]    bit_idx
);

    localparam int GW = (GAP > 2) ? $clog2(GAP) : 1;
    localparam logic [IW-1:0] BIT_LAST = IW'(WIDTH - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'((GAP > 0) ? GAP - 1 : 0);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEND   = 2'd1,
        GAP_ST = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t           ps, ns;
    logic [WIDTH-1:0] pat;
    logic [WIDTH-1:0] sreg;
    logic [IW-1:0]    bit_cnt;
    logic [2:0]       remaining;
    logic [GW-1:0]    gap_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) ps <= IDLE;
        else     ps <= ns;
    end

    always_comb begin
        ns = ps;
        case (ps)
            IDLE:    if (start) ns = SEND;
            SEND: begin
                if (bit_cnt == '0) begin
                    if (remaining == 3'd0) ns = DONE;
                    else if (GAP > 0)      ns = GAP_ST;
                    else                   ns = SEND;
                end
            end
            GAP_ST:  if (gap_cnt == '0) ns = SEND;
            DONE:    ns = IDLE;
            default: ns = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pat       <= '0;
            sreg      <= '0;
            bit_cnt   <= '0;
            remaining <= '0;
            gap_cnt   <= '0;
        end else begin
            case (ps)
                IDLE: begin
                    if (start) begin
                        pat       <= data;
                        sreg      <= data;
                        remaining <= frames;
                        bit_cnt   <= BIT_LAST;
                    end
                end
                SEND: begin
                    if (bit_cnt != '0) begin
                        sreg    <= sreg << 1;
                        bit_cnt <= bit_cnt - 1'b1;
                    end else if (remaining != 3'd0) begin
                        remaining <= remaining - 3'd1;
                        // Back-to-back frames reload here; otherwise the GAP exit does it.
                        if (GAP > 0) begin
                            gap_cnt <= GAP_LAST;
                        end else begin
                            sreg    <= pat;
                            bit_cnt <= BIT_LAST;
                        end
                    end
                end
                GAP_ST: begin
                    if (gap_cnt == '0) begin
                        sreg    <= pat;
                        bit_cnt <= BIT_LAST;
                    end else begin
                        gap_cnt <= gap_cnt - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign j       = (ps == SEND) && sreg[WIDTH-1];
    assign busy    = (ps == SEND) || (ps == GAP_ST);
    assign done    = (ps == DONE);
    assign bit_idx = (ps == SEND) ? bit_cnt : '0;

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Bench for seq_pattern_tx: two instances (GAP=2 and GAP=0) checked cycle by cycle against a frame-level expected-output list.
module tb_seq_pattern_tx;
    localparam int W = 4;
    localparam int G = 2;

    typedef struct packed {
        logic       j;
        logic       busy;
        logic       done;
        logic [1:0] idx;
    } obs_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         start_a, start_b;
    logic [W-1:0] data_a, data_b;
    logic [2:0]   frames_a, frames_b;
    logic         j_a, busy_a, done_a, j_b, busy_b, done_b;
    logic [1:0]   idx_a, idx_b;

    int n_assert = 0;
    int n_fail   = 0;
    obs_t exp_q[$];

    always #5 clk = ~clk;

    seq_pattern_tx #(.WIDTH(W), .GAP(G)) u_dut (
        .clk(clk), .rst(rst), .start(start_a), .data(data_a), .frames(frames_a),
        .j(j_a), .busy(busy_a), .done(done_a), .bit_idx(idx_a)
    );

    seq_pattern_tx #(.WIDTH(W), .GAP(0)) u_dut0 (
        .clk(clk), .rst(rst), .start(start_b), .data(data_b), .frames(frames_b),
        .j(j_b), .busy(busy_b), .done(done_b), .bit_idx(idx_b)
    );

    function automatic obs_t mk(input logic jv, input logic bv, input logic dv, input int iv);
        obs_t o;
        o.j = jv; o.busy = bv; o.done = dv; o.idx = 2'(iv);
        return o;
    endfunction

    function automatic obs_t observe(input bit g0);
        obs_t o;
        if (g0) o = {j_b, busy_b, done_b, idx_b};
        else    o = {j_a, busy_a, done_a, idx_a};
        return o;
    endfunction

    task automatic check(input string tag, input obs_t got, input obs_t exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got j=%b busy=%b done=%b idx=%0d, expected j=%b busy=%b done=%b idx=%0d",
                   tag, got.j, got.busy, got.done, got.idx, exp.j, exp.busy, exp.done, exp.idx);
        end
    endtask

    task automatic checki(input string tag, input int got, input int exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic drive(input bit g0, input logic s, input logic [W-1:0] d, input logic [2:0] f);
        if (g0) begin start_b = s; data_b = d; frames_b = f; end
        else    begin start_a = s; data_a = d; frames_a = f; end
    endtask

    // Expected per-cycle outputs of one transmission, from acceptance to the IDLE cycle after done.
    task automatic build(input logic [W-1:0] d, input int fr, input int gap);
        exp_q.delete();
        for (int f = 0; f <= fr; f++) begin
            for (int b = W - 1; b >= 0; b--) exp_q.push_back(mk(d[b], 1'b1, 1'b0, b));
            if (f < fr)
                for (int g = 0; g < gap; g++) exp_q.push_back(mk(1'b0, 1'b1, 1'b0, 0));
        end
        exp_q.push_back(mk(1'b0, 1'b0, 1'b1, 0));
        exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 0));
    endtask

    // Start one run; inputs are scrambled while busy to show they are ignored after capture.
    task automatic run(input string tag, input logic [W-1:0] d, input logic [2:0] fr,
                       input bit g0, input int stop_at, output int hits);
        logic [3:0] hist;
        obs_t       got;
        hist = '0;
        hits = 0;
        build(d, int'(fr), g0 ? 0 : G);
        @(negedge clk);
        drive(g0, 1'b1, d, fr);
        for (int k = 0; k < exp_q.size(); k++) begin
            @(negedge clk);
            got = observe(g0);
            check($sformatf("%s[%0d]", tag, k), got, exp_q[k]);
            hist = {hist[2:0], got.j};
            if (hist == 4'b1011) hits++;
            if (k == stop_at) return;
            if (k == exp_q.size() - 1) drive(g0, 1'b0, W'($urandom), 3'($urandom));
            else                       drive(g0, 1'($urandom), W'($urandom), 3'($urandom));
        end
    endtask

    initial begin
        int hits;
        logic [W-1:0] d;
        rst = 1'b1;
        drive(1'b0, 1'b0, '0, '0);
        drive(1'b1, 1'b0, '0, '0);
        #1;
        check("reset_a", observe(1'b0), mk(1'b0, 1'b0, 1'b0, 0));
        check("reset_b", observe(1'b1), mk(1'b0, 1'b0, 1'b0, 0));
        @(negedge clk);
        rst = 1'b0;

        run("single", 4'b1011, 3'd0, 1'b0, -1, hits);
        run("gap2", 4'b1011, 3'd2, 1'b0, -1, hits);
        checki("gap2_detect", hits, 3);
        run("gap0", 4'b1011, 3'd1, 1'b1, -1, hits);
        checki("gap0_detect", hits, 2);

        for (int r = 0; r < 8; r++)
            run($sformatf("rand%0d", r), W'($urandom), 3'($urandom), 1'($urandom), -1, hits);
        run("max_frames", 4'b1001, 3'd7, 1'b0, -1, hits);

        // Reset lands while frame 2 bit 1 (third bit) is on j.
        run("rst_mid", 4'b1011, 3'd2, 1'b0, W + G + 2, hits);
        rst = 1'b1;
        drive(1'b0, 1'b0, '0, '0);
        #1;
        check("rst_mid_async", observe(1'b0), mk(1'b0, 1'b0, 1'b0, 0));
        @(negedge clk);
        check("rst_mid_held", observe(1'b0), mk(1'b0, 1'b0, 1'b0, 0));
        rst = 1'b0;
        run("after_rst", 4'b1101, 3'd1, 1'b0, -1, hits);

        // start held high: runs repeat with one IDLE cycle after each done.
        d = W'($urandom);
        @(negedge clk);
        drive(1'b0, 1'b1, d, 3'd0);
        for (int k = 0; k < 3 * (W + 2); k++) begin
            int   pos;
            obs_t e;
            @(negedge clk);
            pos = k % (W + 2);
            if (pos < W)       e = mk(d[W-1-pos], 1'b1, 1'b0, W - 1 - pos);
            else if (pos == W) e = mk(1'b0, 1'b0, 1'b1, 0);
            else               e = mk(1'b0, 1'b0, 1'b0, 0);
            check($sformatf("held[%0d]", k), observe(1'b0), e);
            if (k == 3 * (W + 2) - 1) drive(1'b0, 1'b0, d, 3'd0);
        end
        @(negedge clk);
        check("held_stop", observe(1'b0), mk(1'b0, 1'b0, 1'b0, 0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
